sum_uart_tx: RTL

SUM_UART_TX -- requirements
Module: sum_uart_tx

---
 rtl/sum_uart_pkg.sv | 26 ++
 rtl/uart_tx_core.sv | 114 +++++++++++
 rtl/sum_uart_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sum_uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sum_uart_pkg
// Description : Shared types and constants for the operand-sum UART sender:
//               serialiser state encoding, bits per byte, byte-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sum_uart_pkg;

    // Serialiser states: start bit, eight data bits, stop bit
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int BITS_PER_BYTE = 8;

    // Bytes needed to carry a DATA_W+1 bit result: ceil((DATA_W+1)/8)
    function automatic int nbytes(input int data_w);
        return (data_w + BITS_PER_BYTE) / BITS_PER_BYTE;
    endfunction

endpackage : sum_uart_pkg
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_core
// Description : 8N1 serialiser. Accepts one byte per valid/ready handshake,
//               sends start, 8 data bits LSB first, stop, each CLK_DIV clocks.
//               A byte offered during the last stop cycle follows with no gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_core
    import sum_uart_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o
);

    localparam int                 CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]         BIT_LAST = 3'(BITS_PER_BYTE - 1);

    uart_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic             tx_q;
    logic             busy_q;
    logic             w_bit_end;

    assign w_bit_end = (cnt_q == CNT_LAST);

    // A new byte is taken when idle, or at the very end of a stop bit so the
    // next start bit follows without an idle gap.
    assign ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && w_bit_end);
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;

    // Bit-timing FSM with registered line and busy outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (valid_i) begin
                        state_q <= ST_START;
                        sh_q    <= data_i;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        state_q <= ST_DATA;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= sh_q[0];
                        sh_q    <= sh_q >> 1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= sh_q[0];
                            sh_q  <= sh_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        cnt_q <= '0;
                        if (valid_i) begin
                            state_q <= ST_START;
                            sh_q    <= data_i;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule : uart_tx_core
`default_nettype wire

// File: rtl/sum_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : sum_uart_tx
// Description : Latches operands A and B from asynchronous strobes, computes
//               A+B or A-B (DATA_W+1 bits) when B arrives while idle, and
//               sends the result LSB byte first over an 8N1 UART line.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int CLK_DIV = 868
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              save_a_n,
    input  logic              save_b_n,
    input  logic [DATA_W-1:0] data_input,
    input  logic              mode,
    output logic              uart_tx,
    output logic              uart_tx_busy,
    output logic              drop
);

    localparam int RES_W  = DATA_W + 1;
    localparam int NBYTES = nbytes(DATA_W);
    localparam int SH_W   = NBYTES * BITS_PER_BYTE;
    localparam int LEFT_W = $clog2(NBYTES + 1);

    // [0] first sync flop, [1] second sync flop, [2] previous second-flop value
    logic [2:0]        a_sync_q;
    logic [2:0]        b_sync_q;
    logic [DATA_W-1:0] data_s1_q;
    logic [DATA_W-1:0] data_s2_q;
    // Fills with ones after reset; edges are only trusted once every
    // synchroniser stage holds a real sample, so a strobe already low at
    // reset release is not mistaken for a new falling edge.
    logic [2:0]        warm_q;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] a_d;
    logic [DATA_W-1:0] b_d;

    logic [SH_W-1:0]   res_q;
    logic [LEFT_W-1:0] left_q;
    logic              trig_q;
    logic              vld_q;
    logic              drop_q;

    logic              w_a_ev;
    logic              w_b_ev;
    logic              w_block;
    logic              w_trig;
    logic              w_accept;
    logic              w_core_ready;
    logic [RES_W-1:0]  w_result;

    assign w_a_ev   = warm_q[2] & a_sync_q[2] & ~a_sync_q[1];
    assign w_b_ev   = warm_q[2] & b_sync_q[2] & ~b_sync_q[1];
    // A frame is in flight from the trigger until the last stop bit ends
    assign w_block  = uart_tx_busy | trig_q | vld_q;
    assign w_trig   = w_b_ev & ~w_block;
    assign w_accept = vld_q & w_core_ready;
    assign drop     = drop_q;

    // Two-flop synchronisers plus edge-history flop for strobes and data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sync_q  <= 3'b111;
            b_sync_q  <= 3'b111;
            data_s1_q <= '0;
            data_s2_q <= '0;
            warm_q    <= '0;
        end else begin
            a_sync_q  <= {a_sync_q[1:0], save_a_n};
            b_sync_q  <= {b_sync_q[1:0], save_b_n};
            data_s1_q <= data_input;
            data_s2_q <= data_s1_q;
            warm_q    <= {warm_q[1:0], 1'b1};
        end
    end

    // Operand next values and result; a simultaneous trigger sees the new
    // operands so A and B strobed together are both used.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        w_result = '0;
        if (w_a_ev) a_d = data_s2_q;
        if (w_b_ev) b_d = data_s2_q;
        if (mode) w_result = {1'b0, a_d} - {1'b0, b_d};
        else      w_result = {1'b0, a_d} + {1'b0, b_d};
    end

    // Operand registers update on every strobe event, busy or not
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // Result capture and byte sequencing toward the serialiser
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q  <= '0;
            left_q <= '0;
            trig_q <= 1'b0;
            vld_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            trig_q <= w_trig;
            drop_q <= w_b_ev & w_block;
            if (w_trig) begin
                res_q  <= SH_W'(w_result);
                left_q <= LEFT_W'(NBYTES);
            end else if (w_accept) begin
                res_q  <= res_q >> BITS_PER_BYTE;
                left_q <= left_q - LEFT_W'(1);
                vld_q  <= (left_q > LEFT_W'(1));
            end
            // One stage between capture and offer aligns the first start bit
            // four clocks after the strobe is first sampled low.
            if (trig_q) vld_q <= 1'b1;
        end
    end

    uart_tx_core #(
        .CLK_DIV (CLK_DIV)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .data_i  (res_q[7:0]),
        .valid_i (vld_q),
        .ready_o (w_core_ready),
        .tx_o    (uart_tx),
        .busy_o  (uart_tx_busy)
    );

endmodule : sum_uart_tx
`default_nettype wire
